// File: rtl/keylock_code_engine.sv
// Keylock code engine: digit buffer, code comparison, user-code staging/commit,
// lock-state LED and the error/success blink sequencer.
module keylock_code_engine #(
    parameter int unsigned               N_DIGITS    = 4,
    parameter logic [4*N_DIGITS-1:0]     PROG_CODE   = 16'h1234,
    parameter int unsigned               BLINK_HALF  = 25000000,
    parameter int unsigned               BLINK_TIMES = 3
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       rdy_i,
    input  logic [3:0] keypress_i,
    input  logic       check_pc_i,
    input  logic       check_valid_uc_i,
    input  logic       confirm_uc_i,
    input  logic       locking_i,
    input  logic       toggle_led1_i,
    input  logic       error_i,
    input  logic       chillin_i,
    output logic       match_o,
    output logic       valid_uc_o,
    output logic       done_blink_o,
    output logic       led1_o,
    output logic       blink_led_o,
    output logic [2:0] digit_count_o
);

    localparam int unsigned CW = 4 * N_DIGITS;
    localparam int unsigned TW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam int unsigned PW = (BLINK_TIMES > 1) ? $clog2(BLINK_TIMES) : 1;
    localparam logic [2:0]    FULL_CNT  = 3'(N_DIGITS);
    localparam logic [TW-1:0] HALF_LAST = TW'(BLINK_HALF - 1);
    localparam logic [PW-1:0] PAIR_LAST = PW'(BLINK_TIMES - 1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StOn   = 2'd1;
    localparam logic [1:0] StOff  = 2'd2;
    localparam logic [1:0] StDone = 2'd3;

    logic [CW-1:0] buf_q, buf_d, cand_q, cand_d, uc_q, uc_d;
    logic [2:0]    cnt_q, cnt_d;
    logic          ovf_q, ovf_d, uc_set_q, uc_set_d, led_q, led_d, prev_q;
    logic [1:0]    st_q, st_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [PW-1:0] pairs_q, pairs_d;

    logic is_digit, is_cmd, is_repro, full, trig;

    assign is_digit = rdy_i & (keypress_i <= 4'd6);
    assign is_cmd   = rdy_i & (keypress_i >= 4'd7) & (keypress_i <= 4'd9);
    assign is_repro = rdy_i & (keypress_i == 4'd8);
    assign full     = (cnt_q == FULL_CNT) & ~ovf_q;
    assign trig     = (error_i | chillin_i) & ~prev_q;

    // Reference selection and comparison outputs
    always_comb begin
        match_o = 1'b0;
        if (check_pc_i) begin
            match_o = full & (buf_q == PROG_CODE);
        end else if (confirm_uc_i) begin
            match_o = full & (buf_q == cand_q);
        end else if (locking_i) begin
            match_o = full & uc_set_q & (buf_q == uc_q);
        end
        valid_uc_o = full & (buf_q != PROG_CODE);
    end

    // Digit entry, user-code staging/commit and lock-state next values
    always_comb begin
        buf_d    = buf_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        cand_d   = cand_q;
        uc_d     = uc_q;
        uc_set_d = uc_set_q;
        led_d    = toggle_led1_i ? ~led_q : led_q;
        if (is_cmd) begin
            buf_d = '0;
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (is_digit) begin
            if (cnt_q < FULL_CNT) begin
                buf_d = {buf_q[CW-5:0], keypress_i};
                cnt_d = cnt_q + 3'd1;
            end else begin
                ovf_d = 1'b1;
            end
        end
        if (check_valid_uc_i & is_repro & valid_uc_o) begin
            cand_d = buf_q;
        end
        if (confirm_uc_i & is_repro & match_o) begin
            uc_d     = cand_q;
            uc_set_d = 1'b1;
        end
    end

    // Blink sequencer next state; a trigger outside idle is ignored
    always_comb begin
        st_d    = st_q;
        timer_d = timer_q;
        pairs_d = pairs_q;
        unique case (st_q)
            StIdle: begin
                if (trig) begin
                    st_d    = StOn;
                    timer_d = '0;
                    pairs_d = '0;
                end
            end
            StOn: begin
                if (timer_q == HALF_LAST) begin
                    st_d    = StOff;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StOff: begin
                if (timer_q == HALF_LAST) begin
                    timer_d = '0;
                    pairs_d = pairs_q + 1'b1;
                    st_d    = (pairs_q == PAIR_LAST) ? StDone : StOn;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: st_d = StIdle;
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            buf_q    <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            cand_q   <= '0;
            uc_q     <= '0;
            uc_set_q <= 1'b0;
            led_q    <= 1'b0;
            prev_q   <= 1'b0;
            st_q     <= StIdle;
            timer_q  <= '0;
            pairs_q  <= '0;
        end else begin
            buf_q    <= buf_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            cand_q   <= cand_d;
            uc_q     <= uc_d;
            uc_set_q <= uc_set_d;
            led_q    <= led_d;
            prev_q   <= error_i | chillin_i;
            st_q     <= st_d;
            timer_q  <= timer_d;
            pairs_q  <= pairs_d;
        end
    end

    assign led1_o        = led_q;
    assign blink_led_o   = (st_q == StOn);
    assign done_blink_o  = (st_q == StDone);
    assign digit_count_o = cnt_q;

endmodule

// File: tb/tb_keylock_code_engine.sv
// Self-checking bench for keylock_code_engine with a short blink timing.
module tb_keylock_code_engine;

    logic       clk = 1'b0;
    logic       reset, rdy, check_pc, check_valid_uc, confirm_uc, locking;
    logic       toggle_led1, error, chillin;
    logic [3:0] keypress;
    logic       match, valid_uc, done_blink, led1, blink_led;
    logic [2:0] digit_count;

    int total = 0;
    int bad   = 0;
    logic       exp_q[$];
    logic [1:0] exp_blink_q[$];

    keylock_code_engine #(
        .N_DIGITS   (4),
        .PROG_CODE  (16'h1234),
        .BLINK_HALF (4),
        .BLINK_TIMES(2)
    ) dut (
        .clk_i           (clk),
        .reset_i         (reset),
        .rdy_i           (rdy),
        .keypress_i      (keypress),
        .check_pc_i      (check_pc),
        .check_valid_uc_i(check_valid_uc),
        .confirm_uc_i    (confirm_uc),
        .locking_i       (locking),
        .toggle_led1_i   (toggle_led1),
        .error_i         (error),
        .chillin_i       (chillin),
        .match_o         (match),
        .valid_uc_o      (valid_uc),
        .done_blink_o    (done_blink),
        .led1_o          (led1),
        .blink_led_o     (blink_led),
        .digit_count_o   (digit_count)
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge; outputs sampled 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ctrl();
        check_pc = 0; check_valid_uc = 0; confirm_uc = 0; locking = 0;
    endtask

    task automatic press(input logic [3:0] k);
        rdy = 1; keypress = k;
        tick();
        rdy = 0; keypress = 4'hf;
    endtask

    task automatic enter4(input logic [15:0] code);
        for (int i = 3; i >= 0; i--) press(code[4*i +: 4]);
    endtask

    // Command key with the expected match value pushed first, then popped and compared.
    task automatic cmd_match(input string name, input logic [3:0] k, input logic exp);
        logic e;
        exp_q.push_back(exp);
        rdy = 1; keypress = k;
        #1;
        e = exp_q.pop_front();
        total++;
        if (match !== e) begin
            bad++;
            $display("FAIL %s: match=%b expected %b", name, match, e);
        end
        tick();
        rdy = 0; keypress = 4'hf;
    endtask

    task automatic cmd_valid(input string name, input logic [3:0] k, input logic exp);
        logic e;
        exp_q.push_back(exp);
        rdy = 1; keypress = k;
        #1;
        e = exp_q.pop_front();
        total++;
        if (valid_uc !== e) begin
            bad++;
            $display("FAIL %s: ValidUC=%b expected %b", name, valid_uc, e);
        end
        tick();
        rdy = 0; keypress = 4'hf;
    endtask

    task automatic check_count(input string name, input logic [2:0] exp);
        total++;
        if (digit_count !== exp) begin
            bad++;
            $display("FAIL %s: digit_count=%0d expected %0d", name, digit_count, exp);
        end
    endtask

    task automatic test_reset();
        reset = 1; rdy = 0; keypress = 4'hf; toggle_led1 = 0; error = 0; chillin = 0;
        clear_ctrl();
        check_pc = 1;
        tick(); tick();
        #1;
        total++;
        if ({match, valid_uc, done_blink, led1, blink_led, digit_count} !== 8'b0) begin
            bad++;
            $display("FAIL reset: outs=%b expected %b",
                     {match, valid_uc, done_blink, led1, blink_led, digit_count}, 8'b0);
        end
        reset = 0;
        tick();
        check_pc = 0;
    endtask

    task automatic test_pc_match();
        check_pc = 1;
        enter4(16'h1234);
        check_count("pc_count_full", 3'd4);
        cmd_match("pc_match", 4'd8, 1'b1);
        #1;
        check_count("pc_count_cleared", 3'd0);
        check_pc = 0;
    endtask

    task automatic test_overflow_short();
        check_pc = 1;
        enter4(16'h1234);
        press(4'd5);
        check_count("ovf_count_sat", 3'd4);
        cmd_match("ovf_match", 4'd8, 1'b0);
        press(4'd1); press(4'd2); press(4'd3);
        cmd_match("short_match", 4'd8, 1'b0);
        // Keys 10-15 are ignored.
        press(4'd12);
        check_count("ignored_key", 3'd0);
        check_pc = 0;
    endtask

    task automatic test_lock_unset();
        locking = 1;
        enter4(16'h5601);
        cmd_match("lock_unset", 4'd9, 1'b0);
        enter4(16'h0000);
        cmd_match("lock_unset_zero", 4'd9, 1'b0);
        locking = 0;
    endtask

    task automatic test_uc_program();
        check_valid_uc = 1;
        enter4(16'h5601);
        cmd_valid("uc_valid", 4'd8, 1'b1);
        check_valid_uc = 0;
        confirm_uc = 1;
        enter4(16'h5602);
        cmd_match("uc_confirm_wrong", 4'd7, 1'b0);
        enter4(16'h5601);
        cmd_match("uc_confirm", 4'd8, 1'b1);
        confirm_uc = 0;
        check_valid_uc = 1;
        enter4(16'h1234);
        cmd_valid("uc_is_pc", 4'd7, 1'b0);
        check_valid_uc = 0;
    endtask

    task automatic test_lock_set();
        locking = 1;
        enter4(16'h5601);
        cmd_match("lock_set", 4'd9, 1'b1);
        enter4(16'h5610);
        cmd_match("lock_wrong", 4'd9, 1'b0);
        // CheckPC takes priority over LOCKING.
        check_pc = 1;
        enter4(16'h5601);
        cmd_match("priority_pc", 4'd9, 1'b0);
        check_pc = 0;
        locking = 0;
    endtask

    task automatic test_led();
        logic [1:0] seen;
        toggle_led1 = 1; tick(); toggle_led1 = 0;
        seen[0] = led1;
        tick();
        toggle_led1 = 1; tick(); toggle_led1 = 0;
        seen[1] = led1;
        total++;
        if (seen !== 2'b01) begin
            bad++;
            $display("FAIL led_toggle: LED1 after pulses=%b expected %b", seen, 2'b01);
        end
    endtask

    task automatic test_blink();
        logic [1:0] e;
        for (int k = 1; k <= 20; k++) begin
            exp_blink_q.push_back({((k >= 1 && k <= 4) || (k >= 9 && k <= 12)), (k == 17)});
        end
        error = 1;  // cycle 0
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 5) error = 0;
            if (k == 6) error = 1;
            #1;
            e = exp_blink_q.pop_front();
            total++;
            if ({blink_led, done_blink} !== e) begin
                bad++;
                $display("FAIL blink_c%0d: led,done=%b expected %b",
                         k, {blink_led, done_blink}, e);
            end
        end
        error = 0;
        tick(); tick();
    endtask

    task automatic test_reset_mid();
        logic [1:0] e;
        int dones = 0;
        for (int k = 1; k <= 22; k++) begin
            exp_blink_q.push_back({(k >= 1 && k <= 3), 1'b0});
        end
        chillin = 1; rdy = 1; keypress = 4'd1;  // cycle 0
        for (int k = 1; k <= 22; k++) begin
            tick();
            if (k == 1) keypress = 4'd2;
            if (k == 2) begin
                rdy = 0; keypress = 4'hf; chillin = 0;
                #1;
                check_count("mid_count_before", 3'd2);
            end
            if (k == 3) reset = 1;
            if (k == 4) begin
                reset = 0;
                #1;
                check_count("mid_count_after", 3'd0);
            end
            #1;
            if (done_blink) dones++;
            e = exp_blink_q.pop_front();
            total++;
            if ({blink_led, done_blink} !== e) begin
                bad++;
                $display("FAIL rst_blink_c%0d: led,done=%b expected %b",
                         k, {blink_led, done_blink}, e);
            end
        end
        total++;
        if (dones !== 0) begin
            bad++;
            $display("FAIL rst_no_done: pulses=%0d expected 0", dones);
        end
    endtask

    initial begin
        test_reset();
        test_pc_match();
        test_overflow_short();
        test_lock_unset();
        test_uc_program();
        test_lock_set();
        test_led();
        test_blink();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
